answer_entry: RTL and testbench

ANSWER_ENTRY -- requirements
Module: answer_entry

---
 rtl/answer_entry.sv | 108 ++++++++++
 tb/tb_answer_entry.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/answer_entry.sv
// answer_entry: three-digit answer entry driven by raw buttons; commits digits to the checker.
// Define DEBOUNCE_EN to add a per-button stable-level filter ahead of edge detection.
module answer_entry #(
  parameter logic [19:0] DEBOUNCE_CYCLES = 20'd500000,
  parameter logic [3:0]  MAX_DIGIT       = 4'd9
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       BTN_SEL,
  input  logic       BTN_INC,
  input  logic       BTN_CLR,
  input  logic       BTN_SUBMIT,
  output logic [3:0] COUNT1_OUT,
  output logic [3:0] COUNT2_OUT,
  output logic [3:0] COUNT3_OUT,
  output logic [3:0] EDIT1,
  output logic [3:0] EDIT2,
  output logic [3:0] EDIT3,
  output logic [1:0] SEL_DIGIT,
  output logic       SUBMIT_PULSE
);
  typedef enum logic [1:0] {IDLE, EDIT, LOCK} state_t;
  state_t          state_q, state_d;
  logic [3:0]      sync1_q, sync2_q, lvl, prev_q, press_q;
  logic [2:0][3:0] edit_q, edit_d, count_q, count_d;
  logic [1:0]      sel_q, sel_d;
  logic            pulse_q, pulse_d;
  // Button bit order: 0 SEL, 1 INC, 2 SUBMIT, 3 CLR (higher bit wins)
  always_ff @(posedge CLK or negedge RST)
    if (!RST) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= {BTN_CLR, BTN_SUBMIT, BTN_INC, BTN_SEL};
      sync2_q <= sync1_q;
    end
`ifdef DEBOUNCE_EN
  logic [19:0] cnt_q [4];
  logic [3:0]  lvl_q;
  always_ff @(posedge CLK or negedge RST)
    if (!RST) begin
      lvl_q <= '0;
      for (int i = 0; i < 4; i++) cnt_q[i] <= '0;
    end else begin
      for (int i = 0; i < 4; i++)
        if (sync2_q[i] == lvl_q[i]) cnt_q[i] <= '0;
        else if (cnt_q[i] == DEBOUNCE_CYCLES - 20'd1) begin
          cnt_q[i] <= '0;
          lvl_q[i] <= sync2_q[i];
        end else cnt_q[i] <= cnt_q[i] + 20'd1;
    end
  assign lvl = lvl_q;
`else
  logic unused_debounce;
  assign unused_debounce = ^DEBOUNCE_CYCLES;
  assign lvl = sync2_q;
`endif
  always_ff @(posedge CLK or negedge RST)
    if (!RST) begin
      prev_q  <= '0;
      press_q <= '0;
    end else begin
      prev_q  <= lvl;
      press_q <= lvl & ~prev_q;
    end
  always_comb begin
    state_d = state_q;
    edit_d  = edit_q;
    sel_d   = sel_q;
    count_d = count_q;
    pulse_d = 1'b0;
    if (press_q[3]) begin
      edit_d  = '0;
      sel_d   = 2'd0;
      state_d = EDIT;
    end else if (press_q[2]) begin
      if (state_q == EDIT && |edit_q) begin
        count_d = edit_q;
        pulse_d = 1'b1;
        state_d = LOCK;
      end
    end else if (press_q[1] && state_q != LOCK) begin
      edit_d[sel_q] = edit_q[sel_q] >= MAX_DIGIT ? 4'd0 : edit_q[sel_q] + 4'd1;
      state_d = EDIT;
    end else if (press_q[0] && state_q != LOCK) begin
      sel_d   = sel_q == 2'd2 ? 2'd0 : sel_q + 2'd1;
      state_d = EDIT;
    end
  end
  always_ff @(posedge CLK or negedge RST)
    if (!RST) begin
      state_q <= IDLE;
      edit_q  <= '0;
      sel_q   <= '0;
      count_q <= '0;
      pulse_q <= 1'b0;
    end else begin
      state_q <= state_d;
      edit_q  <= edit_d;
      sel_q   <= sel_d;
      count_q <= count_d;
      pulse_q <= pulse_d;
    end
  assign {COUNT3_OUT, COUNT2_OUT, COUNT1_OUT} = count_q;
  assign {EDIT3, EDIT2, EDIT1} = edit_q;
  assign SEL_DIGIT    = sel_q;
  assign SUBMIT_PULSE = pulse_q;
endmodule

// File: tb/tb_answer_entry.sv
// tb_answer_entry: directed and random button sequences checked against an integer model of the entry rules.
module tb_answer_entry;
`ifdef DEBOUNCE_EN
  localparam int DB = 8;
`else
  localparam int DB = 0;
`endif
  localparam int LAT  = 4 + DB;
  localparam int HOLD = 2 + DB + 2;
  localparam int WIN  = LAT + HOLD + DB + 4;
  logic CLK = 1'b0, RST = 1'b0;
  logic btn_sel = 0, btn_inc = 0, btn_clr = 0, btn_sub = 0;
  logic [3:0] COUNT1_OUT, COUNT2_OUT, COUNT3_OUT, EDIT1, EDIT2, EDIT3;
  logic [1:0] SEL_DIGIT;
  logic SUBMIT_PULSE;
  int checks = 0, failures = 0;
  int m_edit[3], m_cnt[3], m_sel, m_state;
  always #5 CLK = ~CLK;
  answer_entry #(.DEBOUNCE_CYCLES(20'd8), .MAX_DIGIT(4'd9)) dut (
    .CLK(CLK), .RST(RST), .BTN_SEL(btn_sel), .BTN_INC(btn_inc), .BTN_CLR(btn_clr),
    .BTN_SUBMIT(btn_sub), .COUNT1_OUT(COUNT1_OUT), .COUNT2_OUT(COUNT2_OUT),
    .COUNT3_OUT(COUNT3_OUT), .EDIT1(EDIT1), .EDIT2(EDIT2), .EDIT3(EDIT3),
    .SEL_DIGIT(SEL_DIGIT), .SUBMIT_PULSE(SUBMIT_PULSE));
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask
  task automatic check_all(input string tag);
    chk({tag, ".edit1"}, EDIT1, m_edit[0]);
    chk({tag, ".edit2"}, EDIT2, m_edit[1]);
    chk({tag, ".edit3"}, EDIT3, m_edit[2]);
    chk({tag, ".sel"}, SEL_DIGIT, m_sel);
    chk({tag, ".count1"}, COUNT1_OUT, m_cnt[0]);
    chk({tag, ".count2"}, COUNT2_OUT, m_cnt[1]);
    chk({tag, ".count3"}, COUNT3_OUT, m_cnt[2]);
  endtask
  function automatic void model_reset();
    m_edit = '{0, 0, 0};
    m_cnt = '{0, 0, 0};
    m_sel = 0;
    m_state = 0;
  endfunction
  // state: 0 idle, 1 edit, 2 lock; returns 1 when the press commits
  function automatic bit model(input logic [3:0] m);
    if (m[3]) begin
      m_edit = '{0, 0, 0};
      m_sel = 0;
      m_state = 1;
      return 1'b0;
    end
    if (m_state == 2) return 1'b0;
    if (m[2]) begin
      if (m_state == 1 && (m_edit[0] + m_edit[1] + m_edit[2]) != 0) begin
        m_cnt = m_edit;
        m_state = 2;
        return 1'b1;
      end
      return 1'b0;
    end
    if (m[1]) m_edit[m_sel] = (m_edit[m_sel] + 1) % 10;
    else m_sel = (m_sel + 1) % 3;
    m_state = 1;
    return 1'b0;
  endfunction
  task automatic set_btn(input logic [3:0] m, input logic v);
    if (m[0]) btn_sel = v;
    if (m[1]) btn_inc = v;
    if (m[2]) btn_sub = v;
    if (m[3]) btn_clr = v;
  endtask
  task automatic press(input logic [3:0] m, input string tag);
    bit exp_commit;
    int pulses = 0, at = 0;
    exp_commit = model(m);
    set_btn(m, 1'b1);
    for (int i = 1; i <= WIN; i++) begin
      @(negedge CLK);
      if (i == HOLD) set_btn(m, 1'b0);
      if (SUBMIT_PULSE) begin
        pulses++;
        at = i;
      end
    end
    chk({tag, ".pulses"}, pulses, {31'd0, exp_commit});
    if (exp_commit) chk({tag, ".pulse_lat"}, at, LAT);
    check_all(tag);
  endtask
  task automatic reset_dut();
    @(negedge CLK);
    RST = 1'b0;
    #1 model_reset();
    check_all("reset");
    chk("reset.pulse", SUBMIT_PULSE, 0);
    repeat (2) @(negedge CLK);
    RST = 1'b1;
  endtask
  initial begin
    model_reset();
    repeat (2) @(negedge CLK);
    check_all("por");
    chk("por.pulse", SUBMIT_PULSE, 0);
    RST = 1'b1;
    repeat (10) press(4'b0010, "wrap_inc");
    press(4'b0100, "zero_submit");
    reset_dut();
    repeat (3) press(4'b0010, "d1_inc");
    press(4'b0001, "sel1");
    repeat (5) press(4'b0010, "d2_inc");
    press(4'b0001, "sel2");
    repeat (9) press(4'b0010, "d3_inc");
    press(4'b0100, "commit");
    press(4'b0010, "lock_inc");
    press(4'b0001, "lock_sel");
    press(4'b0100, "lock_submit");
    press(4'b1000, "lock_clr");
    repeat (4) press(4'b0010, "to_four");
    press(4'b1010, "clr_beats_inc");
    press(4'b0110, "submit_beats_inc");
    btn_inc = 1'b1;
    void'(model(4'b0010));
    repeat (100) @(negedge CLK);
    btn_inc = 1'b0;
    repeat (WIN) @(negedge CLK);
    check_all("hold100");
`ifdef DEBOUNCE_EN
    btn_inc = 1'b1;
    repeat (5) @(negedge CLK);
    btn_inc = 1'b0;
    repeat (20) @(negedge CLK);
    check_all("glitch");
`endif
    for (int n = 0; n < 80; n++) begin
      int r;
      r = $urandom_range(0, 9);
      press(r < 4 ? 4'b0010 : r < 6 ? 4'b0001 : r < 9 ? 4'b0100 : 4'b1000, "rand");
    end
    press(4'b1000, "pre_abort_clr");
    press(4'b0010, "pre_abort_inc");
    btn_sub = 1'b1;
    repeat (LAT - 2) @(negedge CLK);
    RST = 1'b0;
    #1 model_reset();
    check_all("abort");
    chk("abort.pulse", SUBMIT_PULSE, 0);
    btn_sub = 1'b0;
    repeat (2) @(negedge CLK);
    RST = 1'b1;
    begin
      int pulses = 0;
      repeat (WIN) begin
        @(negedge CLK);
        if (SUBMIT_PULSE) pulses++;
      end
      chk("abort.no_pulse", pulses, 0);
    end
    check_all("abort_after");
    @(negedge CLK);
    RST = 1'b0;
    btn_inc = 1'b1;
    #1 model_reset();
    repeat (2) @(negedge CLK);
    RST = 1'b1;
    repeat (LAT - 1) @(negedge CLK);
    chk("held_rst.early", EDIT1, 0);
    repeat (2) @(negedge CLK);
    void'(model(4'b0010));
    chk("held_rst.edit1", EDIT1, m_edit[0]);
    btn_inc = 1'b0;
    repeat (WIN) @(negedge CLK);
    check_all("held_rst");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
